// File: rtl/pixel_operator.sv
// pixel_operator: per-pixel 8-bit grayscale point operator, one pixel per clock.
// Optional PIXEL_OPERATOR_SAT_COUNT_EN adds a 17-bit clip counter on sat_count.
module pixel_operator (
  output logic [0:7]  outbyte,
  input  logic [0:7]  inbyte,
  input  logic [0:7]  threshold,
  input  logic [0:7]  value,
  input  logic [0:1]  select,
  input  logic        clk,
  input  logic        rst
`ifdef PIXEL_OPERATOR_SAT_COUNT_EN
  ,
  output logic [0:16] sat_count
`endif
);

  logic [7:0] pix;
  logic [7:0] thr;
  logic [7:0] ofs;
  logic [1:0] sel;
  logic [8:0] sum;
  logic       under;
  logic [7:0] res;

  assign pix   = inbyte;
  assign thr   = threshold;
  assign ofs   = value;
  assign sel   = select;
  assign sum   = {1'b0, pix} + {1'b0, ofs};
  assign under = pix < ofs;

  always_comb begin
    res = 8'h00;
    unique case (1'b1)
      sel == 2'd0: res = sum[8] ? 8'hFF : sum[7:0];
      sel == 2'd1: res = under ? 8'h00 : pix - ofs;
      sel == 2'd2: res = ~pix;
      sel == 2'd3: res = (pix >= thr) ? 8'hFF : 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outbyte <= 8'h00;
    end else begin
      outbyte <= res;
    end
  end

`ifdef PIXEL_OPERATOR_SAT_COUNT_EN
  logic        clip;
  logic [16:0] cnt;

  // Only brighten overflow and darken underflow count as clipping.
  assign clip = ((sel == 2'd0) && sum[8]) ||
                ((sel == 2'd1) && under);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 17'd0;
    end else if (clip) begin
      cnt <= cnt + 17'd1;
    end
  end

  assign sat_count = cnt;
`endif

endmodule

// File: tb/tb_pixel_operator.sv
// tb_pixel_operator: directed checks of pixel_operator operations,
// async reset, a threshold stream and the optional clip counter.
module tb_pixel_operator;

  logic [0:7] outbyte;
  logic [0:7] inbyte;
  logic [0:7] threshold;
  logic [0:7] value;
  logic [0:1] select;
  logic       clk;
  logic       rst;
`ifdef PIXEL_OPERATOR_SAT_COUNT_EN
  logic [0:16] sat_count;
`endif

  int checks = 0;
  int errors = 0;

  localparam int STREAM_N = 20000;

  pixel_operator dut (
    .outbyte   (outbyte),
    .inbyte    (inbyte),
    .threshold (threshold),
    .value     (value),
    .select    (select),
    .clk       (clk),
    .rst       (rst)
`ifdef PIXEL_OPERATOR_SAT_COUNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] sel,
                      input logic [7:0] px, input logic [7:0] thr,
                      input logic [7:0] val, input logic [7:0] exp);
    @(negedge clk);
    select    = sel;
    inbyte    = px;
    threshold = thr;
    value     = val;
    @(negedge clk);
    check8(tag, outbyte, exp);
  endtask

  function automatic logic [7:0] stream_px(input int i);
    int v;
    v = (i * 73 + (i >> 5)) & 255;
    return v[7:0];
  endfunction

  initial begin
    logic [7:0] prev;
    prev      = 8'h00;
    rst       = 1'b1;
    inbyte    = 8'hAA;
    threshold = 8'd0;
    value     = 8'd0;
    select    = 2'd2;

    #5;
    check8("reset_async", outbyte, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check8("reset_hold", outbyte, 8'h00);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check8("reset_release_invert", outbyte, 8'h55);

    step("thr_159", 2'd3, 8'd159, 8'd160, 8'd0, 8'd0);
    step("thr_160", 2'd3, 8'd160, 8'd160, 8'd0, 8'd255);
    step("thr_255", 2'd3, 8'd255, 8'd160, 8'd0, 8'd255);
    step("thr_0",   2'd3, 8'd0,   8'd160, 8'd0, 8'd0);
    step("thr_zero_thr", 2'd3, 8'd0, 8'd0, 8'd0, 8'd255);
    step("thr_255_255", 2'd3, 8'd255, 8'd255, 8'd0, 8'd255);

    step("brt_100", 2'd0, 8'd100, 8'd0, 8'd60, 8'd160);
    step("brt_195", 2'd0, 8'd195, 8'd0, 8'd60, 8'd255);
    step("brt_200", 2'd0, 8'd200, 8'd0, 8'd60, 8'd255);
    step("brt_0",   2'd0, 8'd0,   8'd0, 8'd60, 8'd60);
    step("brt_pass", 2'd0, 8'd123, 8'd0, 8'd0, 8'd123);

    step("drk_100", 2'd1, 8'd100, 8'd0, 8'd60, 8'd40);
    step("drk_60",  2'd1, 8'd60,  8'd0, 8'd60, 8'd0);
    step("drk_59",  2'd1, 8'd59,  8'd0, 8'd60, 8'd0);
    step("drk_255", 2'd1, 8'd255, 8'd0, 8'd60, 8'd195);
    step("drk_pass", 2'd1, 8'd77, 8'd0, 8'd0, 8'd77);

    step("inv_0f", 2'd2, 8'h0F, 8'd0, 8'd0, 8'hF0);

    // Back-to-back change of op: each edge uses that edge's inputs.
    @(negedge clk);
    select = 2'd0; inbyte = 8'd10; value = 8'd5;
    @(negedge clk);
    check8("switch_a", outbyte, 8'd15);
    select = 2'd1;
    @(negedge clk);
    check8("switch_b", outbyte, 8'd5);

    // Mid-stream reset clears output without waiting for an edge.
    select = 2'd2; inbyte = 8'h00;
    @(posedge clk);
    #3;
    check8("pre_mid_reset", outbyte, 8'hFF);
    rst = 1'b1;
    #1;
    check8("mid_reset_async", outbyte, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    select    = 2'd3;
    threshold = 8'd160;
    value     = 8'd0;
    for (int i = 0; i <= STREAM_N; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check8("stream", outbyte, (prev >= 8'd160) ? 8'd255 : 8'd0);
      end
      if (i < STREAM_N) begin
        prev   = stream_px(i);
        inbyte = prev;
      end
    end

`ifdef PIXEL_OPERATOR_SAT_COUNT_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    assert (sat_count === 17'd0) else begin
      errors++;
      $error("FAIL sat_reset0: observed=%0d expected=0", sat_count);
    end
    @(negedge clk);
    rst = 1'b0;
    select = 2'd0; value = 8'd60; inbyte = 8'd200;
    @(negedge clk);
    inbyte = 8'd100;
    @(negedge clk);
    inbyte = 8'd250;
    @(negedge clk);
    inbyte = 8'd10;
    @(negedge clk);
    checks++;
    assert (sat_count === 17'd2) else begin
      errors++;
      $error("FAIL sat_count: observed=%0d expected=2", sat_count);
    end
    check8("sat_last_out", outbyte, 8'd70);
    rst = 1'b1;
    #1;
    checks++;
    assert (sat_count === 17'd0) else begin
      errors++;
      $error("FAIL sat_reset: observed=%0d expected=0", sat_count);
    end
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
